song_reader: RTL and testbench

//   Sequencer upstream of note_timer in the music-player datapath. Walks the note

---
 rtl/song_reader_pkg.sv | 48 ++++
 rtl/song_reader_rom.sv | 10 +
 rtl/song_reader.sv | 79 +++++++
 tb/tb_song_reader.sv | 135 +++++++++++++
 4 files changed

// File: rtl/song_reader_pkg.sv
// song_reader_pkg: shared widths, FSM encodings, ROM word layout and song table
package song_reader_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam int IDX_W = 5;
  localparam int SONG_W = 2;
  localparam int WORD_W = NOTE_W + DUR_W;
  localparam int ADDR_W = SONG_W + IDX_W;
  localparam int DUR_LSB = 0;
  localparam int NOTE_LSB = DUR_W;
  localparam logic [DUR_W-1:0] END_MARKER = '0;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_END   = 3'd5
  } state_t;
  // Song table: 0 is a two-note jingle, 1 fills all 32 slots, 2 and 3 end early
  function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DUR_W-1:0] i;
    logic [NOTE_W-1:0] n;
    logic [DUR_W-1:0] d;
    i = DUR_W'(a[IDX_W-1:0]);
    n = '0;
    d = END_MARKER;
    case (a[ADDR_W-1:IDX_W])
      2'd0: begin
        n = i == 0 ? 6'd12 : i == 1 ? 6'd14 : 6'd0;
        d = i == 0 ? 6'd4 : i == 1 ? 6'd2 : END_MARKER;
      end
      2'd1: begin
        n = i * 6'd3 + 6'd1;
        d = i % 6'd7 + 6'd1;
      end
      2'd2: begin
        n = i < 5 ? 6'd40 + i : 6'd0;
        d = i < 5 ? i + 6'd1 : END_MARKER;
      end
      default: begin
        n = i < 10 ? i * 6'd5 : 6'd0;
        d = i < 10 ? i % 6'd3 + 6'd1 : END_MARKER;
      end
    endcase
    return {n, d};
  endfunction
endpackage

// File: rtl/song_reader_rom.sv
// song_rom: registered song ROM, data valid one cycle after address
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] dout
);
  always_ff @(posedge clk) dout <= rom_word(addr);
endmodule

// File: rtl/song_reader.sv
// song_reader: walks a song's ROM note list, strobing each note to the note timer
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic              new_note,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              song_done
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [WORD_W-1:0] rom_dout;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0] rom_dur;
  logic song_sw;
  song_rom u_rom (
    .clk (clk),
    .addr({song_q, idx_q}),
    .dout(rom_dout)
  );
  assign rom_note = rom_dout[NOTE_LSB +: NOTE_W];
  assign rom_dur = rom_dout[DUR_LSB +: DUR_W];
  assign song_sw = song != song_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    song_d = song_q;
    note_d = note_q;
    dur_d = dur_q;
    case (state_q)
      S_IDLE: begin
        state_d = play ? S_FETCH : S_IDLE;
        song_d = play ? song : song_q;
      end
      S_FETCH: state_d = song_sw ? S_IDLE : S_LOAD;
      S_LOAD: begin
        state_d = song_sw ? S_IDLE : rom_dur == END_MARKER ? S_END : S_ISSUE;
        note_d = state_d == S_ISSUE ? rom_note : note_q;
        dur_d = state_d == S_ISSUE ? rom_dur : dur_q;
      end
      S_ISSUE: state_d = song_sw ? S_IDLE : S_WAIT;
      S_WAIT: begin
        state_d = song_sw ? S_IDLE : !(note_done && play) ? S_WAIT : idx_q == '1 ? S_END : S_FETCH;
        idx_d = state_d == S_FETCH ? idx_q + 1'b1 : idx_q;
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Leaving for IDLE mid-song (song change or end) always rewinds
    if (state_d == S_IDLE && state_q != S_IDLE) idx_d = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      song_q <= '0;
      note_q <= '0;
      dur_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      song_q <= song_d;
      note_q <= note_d;
      dur_q <= dur_d;
    end
  end
  assign new_note = state_q == S_ISSUE;
  assign song_done = state_q == S_END;
  assign note = note_q;
  assign duration = dur_q;
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed spec scenarios then random play/pause/song changes vs a reference model
module tb_song_reader;
  logic clk = 0, reset = 1, play = 0, note_done = 0;
  logic [1:0] song = 0;
  logic new_note, song_done;
  logic [5:0] note, duration;
  int n_tests = 0, n_fail = 0;
  int m_mode = 0, m_eta = 0, m_idx = 0, m_sel = 0, m_note = 0, m_dur = 0;
  logic prev_nn = 0;
  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .new_note(new_note), .note(note), .duration(duration), .song_done(song_done)
  );
  always #5 clk = ~clk;
  function automatic int ref_note(int s, int i);
    case (s)
      0: return i == 0 ? 12 : i == 1 ? 14 : 0;
      1: return (3 * i + 1) % 64;
      2: return i < 5 ? 40 + i : 0;
      default: return i < 10 ? (5 * i) % 64 : 0;
    endcase
  endfunction
  function automatic int ref_dur(int s, int i);
    case (s)
      0: return i == 0 ? 4 : i == 1 ? 2 : 0;
      1: return i % 7 + 1;
      2: return i < 5 ? i + 1 : 0;
      default: return i < 10 ? i % 3 + 1 : 0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // mode 0 idle, 1 playing (eta = cycles until the strobe, -1 waiting on timer), 2 end pulse
  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_idx = 0; m_sel = 0; m_note = 0; m_dur = 0; m_eta = 0;
    end else if (m_mode == 0) begin
      if (play) begin m_mode = 1; m_eta = 2; m_sel = int'(song); end
    end else if (m_mode == 2) begin
      m_mode = 0; m_idx = 0;
    end else if (int'(song) != m_sel) begin
      m_mode = 0; m_idx = 0;
    end else if (m_eta == 2) m_eta = 1;
    else if (m_eta == 1) begin
      if (ref_dur(m_sel, m_idx) == 0) m_mode = 2;
      else begin m_note = ref_note(m_sel, m_idx); m_dur = ref_dur(m_sel, m_idx); m_eta = 0; end
    end else if (m_eta == 0) m_eta = -1;
    else if (note_done && play) begin
      if (m_idx == 31) m_mode = 2;
      else begin m_idx++; m_eta = 2; end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("new_note", 32'(new_note), 32'(m_mode == 1 && m_eta == 0));
    check("song_done", 32'(song_done), 32'(m_mode == 2));
    check("note", 32'(note), m_note);
    check("duration", 32'(duration), m_dur);
    check("excl", 32'(new_note & song_done), 0);
    check("double", 32'(prev_nn & new_note), 0);
    prev_nn = new_note;
  endtask
  task automatic wait_strobe();
    for (int k = 0; k < 8 && !new_note; k++) tick();
    check("strobe_timeout", 32'(new_note), 1);
  endtask
  initial begin
    tick(); tick();
    check("rst_nn", 32'(new_note), 0);
    check("rst_sd", 32'(song_done), 0);
    check("rst_note", 32'(note), 0);
    check("rst_dur", 32'(duration), 0);
    reset = 0; play = 1; song = 0;
    tick(); tick(); tick();
    check("t1_nn", 32'(new_note), 1);
    check("t1_note", 32'(note), 12);
    check("t1_dur", 32'(duration), 4);
    repeat (5) tick();
    check("t1_hold", 32'(new_note), 0);
    note_done = 1; tick(); note_done = 0; tick(); tick();
    check("t2_nn", 32'(new_note), 1);
    check("t2_note", 32'(note), 14);
    check("t2_dur", 32'(duration), 2);
    tick(); note_done = 1; tick(); note_done = 0; tick(); tick();
    check("t3_sd", 32'(song_done), 1);
    check("t3_nn", 32'(new_note), 0);
    song = 1; tick();
    check("t3_sd_off", 32'(song_done), 0);
    check("t3_note_held", 32'(note), 14);
    for (int i = 0; i < 32; i++) begin
      wait_strobe();
      check("t4_note", 32'(note), ref_note(1, i));
      check("t4_dur", 32'(duration), ref_dur(1, i));
      tick(); note_done = 1; tick(); note_done = 0;
    end
    check("t4_sd", 32'(song_done), 1);
    repeat (4) tick();
    check("t4_restart_nn", 32'(new_note), 1);
    check("t4_restart_note", 32'(note), 1);
    tick(); play = 0; note_done = 1;
    repeat (10) tick();
    check("t5_pause", 32'(new_note), 0);
    play = 1; tick(); note_done = 0; tick(); tick();
    check("t5_nn", 32'(new_note), 1);
    check("t5_note", 32'(note), 4);
    tick(); song = 2; play = 0; tick();
    check("t6_sd", 32'(song_done), 0);
    check("t6_note_held", 32'(note), 4);
    play = 1; tick(); tick(); tick();
    check("t6_nn", 32'(new_note), 1);
    check("t6_note", 32'(note), 40);
    check("t6_dur", 32'(duration), 1);
    reset = 1; tick();
    check("t6_rst_nn", 32'(new_note), 0);
    check("t6_rst_note", 32'(note), 0);
    check("t6_rst_dur", 32'(duration), 0);
    reset = 0;
    repeat (4000) begin
      play = $urandom_range(0, 7) != 0;
      note_done = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 255) == 0) song = 2'($urandom_range(0, 3));
      reset = $urandom_range(0, 999) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
